// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for a 5-stage in-order pipeline.
// Drives PC/pipeline-register enables and bubble flushes, plus perf counters.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_use_hz,
  input  logic        branch_taken_ex,
  input  logic        mem_req_mem,
  input  logic        mem_ready,
  input  logic        halt_req,
  input  logic        resume,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_we,
  output logic        exmem_we,
  output logic        memwb_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10,
    BAD      = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] stall_q, stall_d;
  logic [15:0] flush_q, flush_d;
  logic        mem_stall;
  logic        stall_inc;

  assign mem_stall = mem_req_mem & ~mem_ready;

  // Next-state and enable/flush decode; freeze is the default.
  always_comb begin
    state_d    = state_q;
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    idex_we    = 1'b0;
    exmem_we   = 1'b0;
    memwb_we   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (state_q == MEM_WAIT && !mem_ready) begin
          state_d = MEM_WAIT;
        end else if (halt_req) begin
          state_d = HALT;
        end else if (mem_stall) begin
          state_d = MEM_WAIT;
        end else begin
          state_d  = RUN;
          idex_we  = 1'b1;
          exmem_we = 1'b1;
          memwb_we = 1'b1;
          if (branch_taken_ex) begin
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use_hz) begin
            idex_flush = 1'b1;
          end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
          end
        end
      end
      HALT: begin
        if (resume) state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // A stall is any non-halted cycle where the PC does not advance.
  assign stall_inc = ~pc_we & (state_q != HALT);

  // Saturating performance counters.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    if (ifid_flush && flush_q != 16'hFFFF) flush_d = flush_q + 16'd1;
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl.
// Table of RUN-decode vectors plus multi-cycle sequences.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_use_hz, branch_taken_ex, mem_req_mem;
  logic        mem_ready, halt_req, resume;
  logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic        ifid_flush, idex_flush;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pipeline_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .load_use_hz(load_use_hz), .branch_taken_ex(branch_taken_ex),
    .mem_req_mem(mem_req_mem), .mem_ready(mem_ready),
    .halt_req(halt_req), .resume(resume),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
    .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  localparam logic [6:0] FRZ = 7'b0000000;
  localparam logic [6:0] NRM = 7'b1111100;
  localparam logic [6:0] BRF = 7'b1111111;
  localparam logic [6:0] LDU = 7'b0011101;

  // inputs: {load_use, branch, mem_req, mem_ready, halt, resume}
  typedef struct {
    string      name;
    logic [5:0] in;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [6:0] outs();
    return {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
            ifid_flush, idex_flush};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [5:0] v);
    {load_use_hz, branch_taken_ex, mem_req_mem,
     mem_ready, halt_req, resume} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(6'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    vecs[0]  = '{"idle",        6'b000000, NRM};
    vecs[1]  = '{"load_use",    6'b100000, LDU};
    vecs[2]  = '{"branch",      6'b010000, BRF};
    vecs[3]  = '{"br_lu",       6'b110000, BRF};
    vecs[4]  = '{"mem_stall",   6'b001000, FRZ};
    vecs[5]  = '{"mem_done",    6'b001100, NRM};
    vecs[6]  = '{"stall_br",    6'b011000, FRZ};
    vecs[7]  = '{"halt",        6'b000010, FRZ};
    vecs[8]  = '{"halt_br_ms",  6'b011010, FRZ};
    vecs[9]  = '{"resume_run",  6'b000001, NRM};
    vecs[10] = '{"done_lu",     6'b101100, LDU};
    vecs[11] = '{"ready_only",  6'b000100, NRM};

    set_in(6'b0);
    rst_n = 1'b0;
    #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);

    // RUN decode while held in reset: state cannot move.
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].in);
      #3;
      chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
    end
    tick();
    chk("rst_hold_state", 32'(state), 32'd0);
    chk("rst_hold_stall", 32'(stall_cnt), 32'd0);

    // Load-use bubble.
    do_reset();
    load_use_hz = 1'b1;
    #1;
    chk("lu_outs", 32'(outs()), 32'(LDU));
    tick();
    load_use_hz = 1'b0;
    chk("lu_stall", 32'(stall_cnt), 32'd1);
    chk("lu_state", 32'(state), 32'd0);

    // Memory wait: 3 frozen cycles then completion.
    do_reset();
    mem_req_mem = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("mw_frz%0d", c), 32'(outs()), 32'(FRZ));
      chk($sformatf("mw_st%0d", c), 32'(state),
          (c == 1) ? 32'd0 : 32'd1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("mw_done_outs", 32'(outs()), 32'(NRM));
    tick();
    set_in(6'b0);
    chk("mw_state_after", 32'(state), 32'd0);
    chk("mw_stall", 32'(stall_cnt), 32'd3);

    // Branch wins over load-use.
    do_reset();
    branch_taken_ex = 1'b1;
    load_use_hz = 1'b1;
    #1;
    chk("brlu_outs", 32'(outs()), 32'(BRF));
    tick();
    set_in(6'b0);
    chk("brlu_flush", 32'(flush_cnt), 32'd1);
    chk("brlu_stall", 32'(stall_cnt), 32'd0);

    // Branch masked by memory stall, released on ready.
    do_reset();
    mem_req_mem = 1'b1;
    tick();
    chk("bm_state", 32'(state), 32'd1);
    branch_taken_ex = 1'b1;
    #1;
    chk("bm_masked", 32'(outs()), 32'(FRZ));
    tick();
    chk("bm_state2", 32'(state), 32'd1);
    chk("bm_noflush", 32'(flush_cnt), 32'd0);
    mem_ready = 1'b1;
    #1;
    chk("bm_release", 32'(outs()), 32'(BRF));
    tick();
    set_in(6'b0);
    chk("bm_state3", 32'(state), 32'd0);
    chk("bm_flush", 32'(flush_cnt), 32'd1);
    chk("bm_stall", 32'(stall_cnt), 32'd2);

    // Ready with halt in MEM_WAIT goes straight to HALT.
    do_reset();
    mem_req_mem = 1'b1;
    tick();
    mem_ready = 1'b1;
    halt_req = 1'b1;
    #1;
    chk("mwh_outs", 32'(outs()), 32'(FRZ));
    tick();
    set_in(6'b0);
    chk("mwh_state", 32'(state), 32'd2);

    // Halt and resume.
    do_reset();
    halt_req = 1'b1;
    #1;
    chk("h_outs", 32'(outs()), 32'(FRZ));
    tick();
    chk("h_state", 32'(state), 32'd2);
    chk("h_stall0", 32'(stall_cnt), 32'd1);
    for (int c = 0; c < 5; c++) begin
      set_in((c % 2 == 0) ? 6'b111010 : 6'b011000);
      #1;
      chk($sformatf("h_frz%0d", c), 32'(outs()), 32'(FRZ));
      tick();
      chk($sformatf("h_st%0d", c), 32'(state), 32'd2);
    end
    chk("h_stall", 32'(stall_cnt), 32'd1);
    set_in(6'b000001);
    tick();
    set_in(6'b0);
    chk("h_resume", 32'(state), 32'd0);

    // Reset mid-HALT.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("hr_state", 32'(state), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("hr_rst_state", 32'(state), 32'd0);
    chk("hr_rst_stall", 32'(stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("hr_outs", 32'(outs()), 32'(NRM));

    // Stall counter saturation, then async reset mid-MEM_WAIT.
    do_reset();
    mem_req_mem = 1'b1;
    repeat (16'hFFFE) tick();
    chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
    repeat (3) tick();
    chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);
    mem_ready = 1'b1;
    branch_taken_ex = 1'b1;
    tick();
    set_in(6'b0);
    chk("sat_flush", 32'(flush_cnt), 32'd1);
    chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
    mem_req_mem = 1'b1;
    tick();
    chk("sat_mw", 32'(state), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(state), 32'd0);
    chk("ar_stall", 32'(stall_cnt), 32'd0);
    chk("ar_flush", 32'(flush_cnt), 32'd0);
    tick();
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
